// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS32-subset core on a single-ported req/ready unified memory.
// Define MIPS_MUL_EN to add SPECIAL2 mul (op 6'h1C, funct 6'h02) via a 32-cycle shift-add unit.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_ADDR_W = 32,
  parameter int          TEST_REG   = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [MEM_ADDR_W-1:0] MemAddr,
  output logic [31:0]           MemWData,
  input  logic [31:0]           MemRData,
  input  logic                  MemReady,
  output logic [31:0]           TestReg,
  output logic                  Halted,
  output logic                  InstrRetired
);

  localparam logic [4:0] TEST_IDX = 5'(TEST_REG);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_MUL
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d;
  logic [31:0] a_q, a_d, b_q, b_d, tgt_q, tgt_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0] regs_q [32];
  logic        reg_we;
  logic [4:0]  reg_wa;
  logic [31:0] reg_wd;
`ifdef MIPS_MUL_EN
  logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
  logic [4:0]  cnt_q, cnt_d;
`endif

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] sext_imm, alu_res;
  logic signed [31:0] a_s, b_s;
  logic        is_r, is_rop, is_jr, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_mul;
  logic        legal, br_taken;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign a_s      = a_q;
  assign b_s      = b_q;

  always_comb begin
    is_r   = (op == 6'h00);
    is_rop = 1'b0;
    if (is_r) begin
      case (funct)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: is_rop = 1'b1;
        default: is_rop = 1'b0;
      endcase
    end
    is_jr   = is_r && (funct == 6'h08);
    is_addi = (op == 6'h08);
    is_lw   = (op == 6'h23);
    is_sw   = (op == 6'h2B);
    is_beq  = (op == 6'h04);
    is_bne  = (op == 6'h05);
    is_j    = (op == 6'h02);
    is_jal  = (op == 6'h03);
`ifdef MIPS_MUL_EN
    is_mul  = (op == 6'h1C) && (funct == 6'h02);
`else
    is_mul  = 1'b0;
`endif
    legal = is_rop | is_jr | is_addi | is_lw | is_sw | is_beq | is_bne | is_j | is_jal | is_mul;
    br_taken = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));
  end

  // Shared ALU: immediate add doubles as load/store address generation
  always_comb begin
    alu_res = a_q + sext_imm;
    if (is_r) begin
      case (funct)
        6'h20:   alu_res = a_q + b_q;
        6'h22:   alu_res = a_q - b_q;
        6'h24:   alu_res = a_q & b_q;
        6'h25:   alu_res = a_q | b_q;
        6'h2A:   alu_res = {31'b0, a_s < b_s};
        6'h00:   alu_res = b_q << shamt;
        6'h02:   alu_res = b_q >> shamt;
        default: alu_res = a_q + b_q;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    tgt_d        = tgt_q;
    alu_d        = alu_q;
    mdr_d        = mdr_q;
    reg_we       = 1'b0;
    reg_wa       = 5'd0;
    reg_wd       = 32'd0;
    MemReq       = 1'b0;
    MemWe        = 1'b0;
    InstrRetired = 1'b0;
`ifdef MIPS_MUL_EN
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    prod_d       = prod_q;
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemReq = 1'b1;
        if (MemReady) begin
          ir_d    = MemRData;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = regs_q[rs];
        b_d     = regs_q[rt];
        tgt_d   = pc_q + (sext_imm << 2);
        state_d = legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        if (is_rop || is_addi) begin
          alu_d   = alu_res;
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          alu_d   = alu_res;
          state_d = (alu_res[1:0] != 2'b00) ? S_HALT : S_MEM;
        end else if (is_beq || is_bne) begin
          if (br_taken) pc_d = tgt_q;
          InstrRetired = 1'b1;
          state_d      = S_FETCH;
        end else if (is_j || is_jal) begin
          pc_d         = {pc_q[31:28], ir_q[25:0], 2'b00};
          reg_we       = is_jal;
          reg_wa       = 5'd31;
          reg_wd       = pc_q;
          InstrRetired = 1'b1;
          state_d      = S_FETCH;
        end else if (is_jr) begin
          pc_d         = a_q;
          InstrRetired = 1'b1;
          state_d      = S_FETCH;
`ifdef MIPS_MUL_EN
        end else if (is_mul) begin
          mcand_d  = a_q;
          mplier_d = b_q;
          prod_d   = 32'd0;
          cnt_d    = 5'd0;
          state_d  = S_MUL;
`endif
        end else begin
          state_d = S_HALT;
        end
      end
      S_MEM: begin
        MemReq = 1'b1;
        MemWe  = is_sw;
        if (MemReady) begin
          if (is_sw) begin
            InstrRetired = 1'b1;
            state_d      = S_FETCH;
          end else begin
            mdr_d   = MemRData;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we       = 1'b1;
        reg_wa       = (is_rop || is_mul) ? rd : rt;
        reg_wd       = is_lw ? mdr_q : alu_q;
        InstrRetired = 1'b1;
        state_d      = S_FETCH;
      end
`ifdef MIPS_MUL_EN
      // One multiplier bit per cycle; only the low 32 product bits are kept
      S_MUL: begin
        prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          alu_d   = prod_d;
          state_d = S_WB;
        end
      end
`endif
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
`ifdef MIPS_MUL_EN
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      prod_q   <= 32'd0;
      cnt_q    <= 5'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      if (reg_we && (reg_wa != 5'd0)) regs_q[reg_wa] <= reg_wd;
`ifdef MIPS_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Operand and result latches carry no architectural state, so they skip reset
  always_ff @(posedge Clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    tgt_q <= tgt_d;
    alu_q <= alu_d;
    mdr_q <= mdr_d;
  end

  assign MemAddr  = (state_q == S_FETCH) ? pc_q[MEM_ADDR_W-1:0] : alu_q[MEM_ADDR_W-1:0];
  assign MemWData = b_q;
  assign TestReg  = regs_q[TEST_IDX];
  assign Halted   = (state_q == S_HALT);

endmodule
